led_bank_loader: RTL
====================

Name: led_bank_loader

Overview:
Command front-end directly upstream of a bank of WIDTH dffr_dis_led cells. It drives each cell's d_i and dis_i and reads the cell outputs back.
- Accepts one command per valid/ready handshake: masked write, bit set, bit clear, or timed rotate.
- Each command becomes per-bit load/hold cycles on the bank.
- Non-selected bits are held through the cell's disable path, so LED state persists between commands.

Parameters:
WIDTH, 8, number of LED cells in the bank (>=2)
DIV, 4, clock cycles between rotate steps (>=1)
STEPW, 4, width of the rotate step count

Ports:
clk_i  in  1  clock, shared with the bank
rst_ni  in  1  asynchronous active-low reset, shared with the bank
valid_i  in  1  command valid
ready_o  out  1  command ready
op_i  in  2  00 write, 01 set, 10 clear, 11 rotate-left
data_i  in  WIDTH  write value / set-clear select
mask_i  in  WIDTH  write enable per bit (write op only)
steps_i  in  STEPW  rotate step count (rotate op only)
abort_i  in  1  stop an in-progress rotate
q_i  in  WIDTH  bank outputs (cell q_o)
d_o  out  WIDTH  to cell d_i
dis_o  out  WIDTH  to cell dis_i (1 = hold)
busy_o  out  1  command in progress

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state IDLE; ready_o=1, busy_o=0, dis_o=all ones, d_o=0.
  - Internal counters and the command register are cleared.
  - Outputs are registered; no combinational path from any input to any output.
- States: IDLE, EXEC, ROT.
- IDLE:
  - ready_o=1, busy_o=0, dis_o=all ones.
  - A command is accepted when valid_i&ready_o at a rising edge; op, data, mask and steps are registered at that edge.
  - Write/set/clear -> EXEC.
  - Rotate with steps_i=0 -> EXEC with dis_o all ones (no-op, one cycle).
  - Rotate with steps_i>0 -> ROT, prescaler=DIV-1, remaining=steps_i.
- EXEC (exactly one cycle):
  - ready_o=0, busy_o=1.
  - write: d_o=data, dis_o=~mask.
  - set: d_o=all ones, dis_o=~data.
  - clear: d_o=0, dis_o=~data.
  - Bank captures at the end of the EXEC cycle; q_i shows the result on the following cycle.
  - Next state IDLE. The earliest next acceptance is 2 edges after the previous one.
- ROT:
  - ready_o=0, busy_o=1.
  - The prescaler decrements each cycle.
  - Tick cycle (prescaler==0): d_o={q_i[WIDTH-2:0],q_i[WIDTH-1]}, dis_o=0; prescaler reloads DIV-1; remaining decrements.
  - Non-tick cycles: dis_o=all ones.
  - After the tick that brings remaining to 0 -> IDLE.
  - Total rotate duration is steps*DIV cycles; the first bank update occurs DIV cycles after acceptance.
  - DIV=1: a tick every cycle.
- abort_i:
  - Sampled in ROT only; ignored elsewhere.
  - If high at a rising edge while in ROT, the next state is IDLE.
  - A tick coinciding with abort still completes, because the bank captures at that same edge. No further ticks follow.
- Additional rules:
  - valid_i while ready_o=0 is ignored; the upstream source holds valid_i.
  - Unused mask/steps bits of a non-matching op are ignored.
  - steps_i is unsigned; its maximum value (2^STEPW-1) is legal. Steps larger than WIDTH simply wrap the pattern.
  - A reset assertion mid-command clears the bank (cell reset) and this block simultaneously. The command is lost; after release the block is in IDLE.
- Rotate reads q_i live each tick, so it rotates the current bank content.

Test Plan:
- Reset, then write data=0xA5 mask=0xFF -> one EXEC cycle with d_o=0xA5, dis_o=0x00; q_i=0xA5 next cycle; ready_o back high.
- From 0xA5: write data=0x00 mask=0x0F -> dis_o=0xF0; bank=0xA0. Set data=0x03 -> bank=0xA3. Clear data=0x80 -> bank=0x23.
- Bank=0x81, rotate steps=3, DIV=4 -> bank 0x03, 0x06, 0x0C at cycles 4, 8 and 12 after acceptance. busy_o high for 12 cycles; ready_o low throughout.
- Rotate steps=0 -> one busy cycle, dis_o=0xFF, bank unchanged. Rotate steps=15, DIV=1 on bank 0x01 -> final bank 0x80.
- Rotate steps=5, DIV=4, abort_i pulsed at cycle 6 -> only 1 step applied; IDLE next cycle. abort_i held on the tick edge -> that step still applied.
- rst_ni low during ROT -> bank=0, dis_o=0xFF, ready_o=1 immediately. valid_i held through reset release -> accepted at the first edge after release.

Source files
------------

// File: rtl/led_bank_loader.sv
// Command front-end for a bank of dffr_dis_led cells: turns write/set/clear/rotate
// commands into registered per-bit load (dis=0) / hold (dis=1) cycles on the bank.
module led_bank_loader #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int STEPW = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic [STEPW-1:0] steps_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] d_o,
    output logic [WIDTH-1:0] dis_o,
    output logic             busy_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ROT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     presc_reg, presc_next;
    logic [STEPW-1:0]  remaining_reg, remaining_next;
    logic [WIDTH-1:0]  d_reg, d_next;
    logic [WIDTH-1:0]  dis_reg, dis_next;
    logic              ready_reg, ready_next;
    logic              busy_reg, busy_next;

    logic              tick;
    logic [WIDTH-1:0]  bank_now;
    logic [WIDTH-1:0]  bank_rot;

    // During a tick the bank is about to capture d_reg, so the next rotate step must
    // start from that value rather than from the not-yet-updated q_i (matters for DIV=1).
    assign tick     = (state_reg == ROT) && (presc_reg == '0);
    assign bank_now = tick ? d_reg : q_i;
    assign bank_rot = {bank_now[WIDTH-2:0], bank_now[WIDTH-1]};

    always_comb begin
        state_next     = state_reg;
        presc_next     = presc_reg;
        remaining_next = remaining_reg;
        d_next         = '0;
        dis_next       = '1;
        ready_next     = 1'b0;
        busy_next      = 1'b1;

        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    case (op_i)
                        2'b00: begin
                            state_next = EXEC;
                            d_next     = data_i;
                            dis_next   = ~mask_i;
                        end
                        2'b01: begin
                            state_next = EXEC;
                            d_next     = '1;
                            dis_next   = ~data_i;
                        end
                        2'b10: begin
                            state_next = EXEC;
                            d_next     = '0;
                            dis_next   = ~data_i;
                        end
                        default: begin
                            if (steps_i == '0) begin
                                state_next = EXEC;
                            end else begin
                                state_next     = ROT;
                                presc_next     = PRESC_RELOAD;
                                remaining_next = steps_i;
                            end
                        end
                    endcase
                end
            end
            EXEC: begin
                state_next = IDLE;
            end
            ROT: begin
                if (tick) begin
                    presc_next     = PRESC_RELOAD;
                    remaining_next = remaining_reg - STEPW'(1);
                    if (remaining_reg == STEPW'(1)) begin
                        state_next = IDLE;
                    end
                end else begin
                    presc_next = presc_reg - PW'(1);
                end
                if (abort_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered, so the load pattern is prepared one cycle ahead.
        if (state_next == ROT && presc_next == '0) begin
            d_next   = bank_rot;
            dis_next = '0;
        end
        if (state_next == IDLE) begin
            ready_next = 1'b1;
            busy_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            remaining_reg <= '0;
            d_reg         <= '0;
            dis_reg       <= '1;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            remaining_reg <= remaining_next;
            d_reg         <= d_next;
            dis_reg       <= dis_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
        end
    end

    assign d_o     = d_reg;
    assign dis_o   = dis_reg;
    assign ready_o = ready_reg;
    assign busy_o  = busy_reg;

endmodule
